// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, 8N1 frame constants and
// the bit-period derivation also used by the transmitter.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } rx_state_e;

  localparam int   DATA_BITS = 8;
  localparam int   STOP_BITS = 1;
  localparam logic LINE_IDLE = 1'b1;

  // Clock cycles per serial bit (truncated) and the start-bit centre offset.
  function automatic int bit_div(input int clock, input int baud);
    return clock / baud;
  endfunction

  function automatic int bit_half(input int clock, input int baud);
    return bit_div(clock, baud) / 2;
  endfunction

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Consumer-facing bundle of the UART receiver: serial line in, byte FIFO out.
interface uart_rx_fifo_if;
  import uart_pkg::*;

  // rxne is the registered "byte available" flag and d is the head byte while
  // rxne is high; a cycle with rd=1 and rxne=1 pops on its rising edge, and
  // rxne then drops for at least one cycle before showing the next byte.
  logic       rx;
  logic       rd;
  logic [7:0] d;
  logic       rxne;
  logic       fe;
  logic       ovr;
  rx_state_e  state;

  modport master (output rx, rd, input d, rxne, fe, ovr, state);
  modport slave  (input rx, rd, output d, rxne, fe, ovr, state);

endinterface

// File: rtl/byte_fifo.sv
// Flop-based byte FIFO with power-of-two depth; storage clears on reset.
module byte_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic         full
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  // A push into a full FIFO only lands when the head leaves on the same edge.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver feeding a byte FIFO; the consumer pops with one-cycle rd
// pulses and watches rxne, fe and ovr.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int CLOCK      = 100_000_000,
  parameter int BAUD_RATE  = 115200,
  parameter int FIFO_DEPTH = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  uart_rx_fifo_if.slave  bus
);

  localparam int DIV  = bit_div(CLOCK, BAUD_RATE);
  localparam int HALF = bit_half(CLOCK, BAUD_RATE);
  localparam int TW   = $clog2(DIV + 1);
  localparam int BW   = $clog2(DATA_BITS);

  logic [1:0]     rx_sync;
  logic           rx_s;
  logic           rx_prev;
  logic [1:0]     rst_sync;
  logic           active;

  rx_state_e      state_q, state_d;
  logic [TW-1:0]  timer_q;
  logic [BW-1:0]  bit_cnt_q;
  logic [7:0]     shreg_q;
  logic           timer_clr;
  logic           shift_en;
  logic           push_req;
  logic           fe_req;

  logic [7:0]     fifo_dout;
  logic           fifo_empty;
  logic           fifo_full;
  logic           pop;
  logic           rxne_q;
  logic           fe_q;
  logic           ovr_q;

  assign rx_s   = rx_sync[1];
  // Nothing may start, push or pop until reset release has crossed two flops.
  assign active = rst_sync[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_sync  <= {2{LINE_IDLE}};
      rx_prev  <= LINE_IDLE;
      rst_sync <= 2'b00;
    end else begin
      rx_sync  <= {rx_sync[0], bus.rx};
      rx_prev  <= rx_s;
      rst_sync <= {rst_sync[0], 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      timer_q   <= '0;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_clr ? '0 : timer_q + 1'b1;
      if (state_q == ST_IDLE) bit_cnt_q <= '0;
      else if (shift_en)      bit_cnt_q <= bit_cnt_q + 1'b1;
      if (shift_en) shreg_q <= {rx_s, shreg_q[7:1]};
    end
  end

  always_comb begin
    state_d   = state_q;
    timer_clr = 1'b0;
    shift_en  = 1'b0;
    push_req  = 1'b0;
    fe_req    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        timer_clr = 1'b1;
        if (active && rx_prev && !rx_s) state_d = ST_START;
      end
      ST_START: begin
        if (timer_q == TW'(HALF - 1)) begin
          timer_clr = 1'b1;
          state_d   = rx_s ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (timer_q == TW'(DIV - 1)) begin
          timer_clr = 1'b1;
          shift_en  = 1'b1;
          if (bit_cnt_q == BW'(DATA_BITS - 1)) state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (timer_q == TW'(DIV - 1)) begin
          timer_clr = 1'b1;
          state_d   = ST_IDLE;
          push_req  = rx_s;
          fe_req    = !rx_s;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign pop = bus.rd && rxne_q && active;

  byte_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_req),
    .pop   (pop),
    .din   (shreg_q),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  // Clearing rxne on every pop guarantees a fresh rising edge per queued byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rxne_q <= 1'b0;
      fe_q   <= 1'b0;
      ovr_q  <= 1'b0;
    end else begin
      rxne_q <= pop ? 1'b0 : !fifo_empty;
      fe_q   <= fe_req;
      ovr_q  <= push_req && fifo_full && !pop;
    end
  end

  assign bus.d     = fifo_dout;
  assign bus.rxne  = rxne_q;
  assign bus.fe    = fe_q;
  assign bus.ovr   = ovr_q;
  assign bus.state = state_q;

endmodule
